// File: rtl/wb_port_arbiter.sv
// Register-file writeback arbiter: merges a buffered pipeline port with a multi-cycle
// unit port, one write per cycle, with a starvation guard for the multi-cycle side.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_valid,
    input  logic [31:0] p_data,
    input  logic [4:0]  p_dest,
    input  logic        p_is_b_type,
    output logic        p_ready,
    input  logic        m_valid,
    input  logic [31:0] m_data,
    input  logic [4:0]  m_dest,
    output logic        m_ready,
    output logic        reg_write_enable,
    output logic [31:0] write_data,
    output logic [4:0]  write_addr,
    output logic        busy
);

    typedef enum logic {
        ARB_PIPE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t  state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [3:0]  starve_q, starve_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  waddr_q, waddr_d;

    logic        pipe_grant;
    logic        m_grant;
    logic        enq;
    logic [36:0] head;

    // Two FIFO slots; contents are don't-care until written, so no reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [36:0] entry_q;
            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_q == 1'(gi))) begin
                    entry_q <= {p_data, p_dest};
                end
            end
        end
    endgenerate

    assign head    = rd_ptr_q ? g_fifo[1].entry_q : g_fifo[0].entry_q;
    assign p_ready = (count_q != 2'd2);
    assign m_ready = m_grant && !rst;
    assign busy    = (count_q != 2'd0) || m_valid;

    assign reg_write_enable = we_q;
    assign write_data       = wdata_q;
    assign write_addr       = waddr_q;

    always_comb begin
        pipe_grant = 1'b0;
        m_grant    = 1'b0;
        case (state_q)
            ARB_FORCE: begin
                m_grant    = m_valid;
                pipe_grant = !m_valid && (count_q != 2'd0);
            end
            default: begin
                pipe_grant = (count_q != 2'd0);
                m_grant    = (count_q == 2'd0) && m_valid;
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        starve_d = 4'd0;
        state_d  = state_q;
        we_d     = 1'b0;
        wdata_d  = 32'd0;
        waddr_d  = 5'd0;

        // Branches and x0 writes are accepted but never occupy a slot.
        enq = p_valid && p_ready && !p_is_b_type && (p_dest != 5'd0);

        if (enq)        wr_ptr_d = ~wr_ptr_q;
        if (pipe_grant) rd_ptr_d = ~rd_ptr_q;

        case ({enq, pipe_grant})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (pipe_grant) begin
            we_d    = 1'b1;
            wdata_d = head[36:5];
            waddr_d = head[4:0];
        end else if (m_grant && (m_dest != 5'd0)) begin
            we_d    = 1'b1;
            wdata_d = m_data;
            waddr_d = m_dest;
        end

        if (m_valid && !m_grant) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end

        // The limit is checked on the value being loaded so the force takes
        // effect in the cycle right after the counter reaches it.
        case (state_q)
            ARB_PIPE: begin
                if (starve_d == LIMIT) state_d = ARB_FORCE;
            end
            ARB_FORCE: begin
                if (m_grant || !m_valid) state_d = ARB_PIPE;
            end
            default: state_d = ARB_PIPE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_PIPE;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            starve_q <= 4'd0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            waddr_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            waddr_q  <= waddr_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter, checked against a queue-based
// model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid;
    logic [31:0] p_data;
    logic [4:0]  p_dest;
    logic        p_is_b_type;
    logic        p_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_dest;
    logic        m_ready;
    logic        reg_write_enable;
    logic [31:0] write_data;
    logic [4:0]  write_addr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_data(p_data), .p_dest(p_dest),
        .p_is_b_type(p_is_b_type), .p_ready(p_ready),
        .m_valid(m_valid), .m_data(m_data), .m_dest(m_dest), .m_ready(m_ready),
        .reg_write_enable(reg_write_enable), .write_data(write_data),
        .write_addr(write_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending pipe writes as a queue, plus the m wait length.
    logic [36:0] mq[$];
    bit          forced;
    int          waited;
    bit          gp, gm;
    bit          exp_p_ready, exp_m_ready, exp_busy, exp_we;
    logic [31:0] exp_data;
    logic [4:0]  exp_addr;

    task automatic model_reset();
        mq.delete();
        forced = 0; waited = 0;
        exp_we = 0; exp_data = 0; exp_addr = 0;
    endtask

    task automatic model_comb();
        exp_p_ready = (mq.size() < 2);
        if (!forced) begin
            gp = (mq.size() > 0);
            gm = !gp && m_valid;
        end else begin
            gm = m_valid;
            gp = !gm && (mq.size() > 0);
        end
        exp_m_ready = gm;
        exp_busy    = (mq.size() > 0) || m_valid;
    endtask

    task automatic model_seq();
        logic [36:0] h;
        exp_we = 0; exp_data = 0; exp_addr = 0;
        if (gp) begin
            h = mq.pop_front();
            exp_we = 1; exp_data = h[36:5]; exp_addr = h[4:0];
        end else if (gm && m_dest != 0) begin
            exp_we = 1; exp_data = m_data; exp_addr = m_dest;
        end
        if (p_valid && exp_p_ready && !p_is_b_type && p_dest != 0) mq.push_back({p_data, p_dest});
        if (m_valid && !gm) waited++; else waited = 0;
        if (!forced) forced = (waited == LIMIT);
        else if (gm || !m_valid) forced = 0;
    endtask

    task automatic apply(input bit pv, input logic [31:0] pd, input logic [4:0] pdst, input bit pb,
                         input bit mv, input logic [31:0] md, input logic [4:0] mdst);
        p_valid = pv; p_data = pd; p_dest = pdst; p_is_b_type = pb;
        m_valid = mv; m_data = md; m_dest = mdst;
        #1;
        model_comb();
    endtask

    task automatic step();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(1, 32'hDEAD, 5'd3, 0, 1, 32'hBEEF, 5'd4);
        @(posedge clk); #1;
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL reset_p_ready got %0b exp 1", p_ready); end
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_m_ready got %0b exp 0", m_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_mvalid got %0b exp 1", busy); end
        checks++; if ({reg_write_enable, write_addr, write_data} !== 38'd0) begin errors++;
            $display("FAIL reset_outputs got we=%0b addr=%0d data=%h exp all 0", reg_write_enable, write_addr, write_data); end
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_idle got %0b exp 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        $display("reset: released");
    endtask

    task automatic test_basic();
        apply(1, 32'h1234, 5'd5, 0, 0, 0, 0);
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL basic_p_ready got %0b exp 1", p_ready); end
        step();
        apply(0, 0, 0, 0, 0, 0, 0);
        step();
        checks++; if (reg_write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'h1234) begin errors++;
            $display("FAIL basic_write got we=%0b addr=%0d data=%h exp 1 5 00001234", reg_write_enable, write_addr, write_data); end
        apply(0, 0, 0, 0, 0, 0, 0);
        step();
        checks++; if (reg_write_enable !== 1'b0 || write_data !== 32'd0) begin errors++;
            $display("FAIL empty_no_write got we=%0b data=%h exp 0 0", reg_write_enable, write_data); end
        $display("basic: write addr=5 data=1234");
    endtask

    task automatic test_drops();
        apply(1, 32'h55, 5'd7, 1, 0, 0, 0);
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL drop_btype_ready got %0b exp 1", p_ready); end
        step();
        apply(1, 32'hFFFF, 5'd0, 0, 0, 0, 0);
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL drop_x0_ready got %0b exp 1", p_ready); end
        step();
        checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL drop_we1 got %0b exp 0", reg_write_enable); end
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0);
            step();
            checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL drop_we_late%0d got %0b exp 0", k, reg_write_enable); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0b exp 0", busy); end
        $display("drops: branch and x0 requests produced no write");
    endtask

    // Preload one entry, then hold an m request under continuous pipe traffic
    // until the DUT grants it; the granting inputs stay applied on return.
    task automatic reach_force(output int grant_at);
        grant_at = 0;
        apply(1, 32'h100, 5'd1, 0, 0, 0, 0);
        step();
        for (int w = 1; w <= 12; w++) begin
            apply(1, 32'h200 + w, 5'(10 + w), 0, 1, 32'hAA, 5'd9);
            checks++; if (m_ready !== exp_m_ready) begin errors++;
                $display("FAIL starve_m_ready w=%0d got %0b exp %0b", w, m_ready, exp_m_ready); end
            if (m_ready) begin
                grant_at = w;
                break;
            end
            step();
            checks++; if (reg_write_enable !== exp_we || write_addr !== exp_addr) begin errors++;
                $display("FAIL starve_write w=%0d got we=%0b addr=%0d exp %0b %0d", w, reg_write_enable, write_addr, exp_we, exp_addr); end
        end
    endtask

    task automatic test_starve_full();
        int g;
        bit mv;
        reach_force(g);
        checks++; if (g !== 5) begin errors++; $display("FAIL starve_grant_cycle got %0d exp 5", g); end
        step();
        checks++; if (reg_write_enable !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'hAA) begin errors++;
            $display("FAIL starve_m_write got we=%0b addr=%0d data=%h exp 1 9 000000aa", reg_write_enable, write_addr, write_data); end
        apply(1, 32'h300, 5'd20, 0, 1, 32'hBB, 5'd10);
        checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL full_p_ready got %0b exp 0", p_ready); end
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL back_to_pipe_m_ready got %0b exp 0", m_ready); end
        step();
        checks++; if (reg_write_enable !== exp_we || write_addr !== exp_addr || write_data !== exp_data) begin errors++;
            $display("FAIL full_order got we=%0b addr=%0d data=%h exp %0b %0d %h", reg_write_enable, write_addr, write_data, exp_we, exp_addr, exp_data); end
        mv = 1;
        for (int k = 0; k < 8; k++) begin
            apply(0, 0, 0, 0, mv, 32'hBB, 5'd10);
            if (k == 0) begin
                checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL after_full_p_ready got %0b exp 1", p_ready); end
            end
            checks++; if (m_ready !== exp_m_ready) begin errors++; $display("FAIL drain_m_ready k=%0d got %0b exp %0b", k, m_ready, exp_m_ready); end
            if (exp_m_ready) mv = 0;
            step();
            checks++; if (reg_write_enable !== exp_we || write_addr !== exp_addr || write_data !== exp_data) begin errors++;
                $display("FAIL drain_write k=%0d got we=%0b addr=%0d data=%h exp %0b %0d %h", k, reg_write_enable, write_addr, write_data, exp_we, exp_addr, exp_data); end
        end
        $display("starve: m granted in waiting cycle %0d, fifo drained in order", g);
    endtask

    task automatic test_simul();
        apply(1, 32'hA1, 5'd3, 0, 0, 0, 0);
        step();
        apply(1, 32'hB2, 5'd4, 0, 0, 0, 0);
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL simul_p_ready got %0b exp 1", p_ready); end
        step();
        checks++; if (reg_write_enable !== 1'b1 || write_addr !== 5'd3 || write_data !== 32'hA1) begin errors++;
            $display("FAIL simul_first got we=%0b addr=%0d data=%h exp 1 3 a1", reg_write_enable, write_addr, write_data); end
        apply(0, 0, 0, 0, 0, 0, 0);
        step();
        checks++; if (reg_write_enable !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'hB2) begin errors++;
            $display("FAIL simul_second got we=%0b addr=%0d data=%h exp 1 4 b2", reg_write_enable, write_addr, write_data); end
        apply(0, 0, 0, 0, 0, 0, 0);
        step();
        checks++; if (reg_write_enable !== 1'b0) begin errors++; $display("FAIL simul_no_dup got %0b exp 0", reg_write_enable); end
        $display("simul: enqueue+dequeue at count 1 wrote 3 then 4");
    endtask

    task automatic test_reset_mid(input int variant);
        int g;
        bit exp_busy_rst;
        reach_force(g);
        if (variant == 1) begin
            step();
            apply(0, 0, 0, 0, 0, 0, 0);
            checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL midrst_full_setup got %0b exp 0", p_ready); end
        end
        exp_busy_rst = (variant == 0);
        rst = 1'b1;
        #1;
        checks++; if (p_ready !== 1'b1 || m_ready !== 1'b0) begin errors++;
            $display("FAIL midrst%0d_ready got p=%0b m=%0b exp 1 0", variant, p_ready, m_ready); end
        checks++; if ({reg_write_enable, write_addr, write_data} !== 38'd0 || busy !== exp_busy_rst) begin errors++;
            $display("FAIL midrst%0d_outputs got we=%0b addr=%0d data=%h busy=%0b exp 0 0 0 %0b", variant, reg_write_enable, write_addr, write_data, busy, exp_busy_rst); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            apply(0, 0, 0, 0, 0, 0, 0);
            checks++; if (m_ready !== 1'b0 || busy !== 1'b0) begin errors++;
                $display("FAIL midrst%0d_idle k=%0d got m=%0b busy=%0b exp 0 0", variant, k, m_ready, busy); end
            step();
            checks++; if (reg_write_enable !== 1'b0) begin errors++;
                $display("FAIL midrst%0d_stale k=%0d got we=%0b addr=%0d exp 0", variant, k, reg_write_enable, write_addr); end
        end
        $display("reset_mid variant %0d: buffered entries discarded", variant);
    endtask

    task automatic test_random();
        bit          mv = 0;
        logic [31:0] md = 0;
        logic [4:0]  mdst = 0;
        int          writes = 0;
        for (int i = 0; i < 600; i++) begin
            if (!mv && $urandom_range(0, 2) == 0) begin
                mv = 1; md = $urandom; mdst = 5'($urandom_range(0, 31));
            end
            apply($urandom_range(0, 9) < 6, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 7) == 0, mv, md, mdst);
            checks++; if (p_ready !== exp_p_ready || m_ready !== exp_m_ready || busy !== exp_busy) begin errors++;
                $display("FAIL rand_comb i=%0d got p=%0b m=%0b busy=%0b exp %0b %0b %0b", i, p_ready, m_ready, busy, exp_p_ready, exp_m_ready, exp_busy); end
            if (exp_m_ready) mv = 0;
            step();
            checks++; if (reg_write_enable !== exp_we || write_addr !== exp_addr || write_data !== exp_data) begin errors++;
                $display("FAIL rand_write i=%0d got we=%0b addr=%0d data=%h exp %0b %0d %h", i, reg_write_enable, write_addr, write_data, exp_we, exp_addr, exp_data); end
            if (exp_we) writes++;
        end
        $display("random: 600 cycles, %0d writes", writes);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_drops();
        test_starve_full();
        test_simul();
        test_reset_mid(0);
        test_reset_mid(1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, the number of consecutive cycles m may wait before a forced grant; legal range is 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port p_valid, input, 1 bit: the pipeline writeback request is valid.
REQ-005 Port p_data, input, 32 bits: the pipeline result.
REQ-006 Port p_dest, input, 5 bits: the pipeline destination register.
REQ-007 Port p_is_b_type, input, 1 bit: the pipeline instruction is a branch and has no writeback.
REQ-008 Port p_ready, output, 1 bit: the pipeline request is accepted this cycle.
REQ-009 Port m_valid, input, 1 bit: the multi-cycle unit (load/mul/div) writeback request is valid.
REQ-010 Port m_data, input, 32 bits: the multi-cycle result.
REQ-011 Port m_dest, input, 5 bits: the multi-cycle destination register.
REQ-012 Port m_ready, output, 1 bit: the multi-cycle request is granted this cycle.
REQ-013 Port reg_write_enable, output, 1 bit: register-file write strobe, registered.
REQ-014 Port write_data, output, 32 bits: register-file write data, registered.
REQ-015 Port write_addr, output, 5 bits: register-file write address, registered.
REQ-016 Port busy, output, 1 bit: asserted when the FIFO is not empty or m_valid is high.

Function
REQ-017 The pipe path is buffered in a 2-entry in-order FIFO holding {data, dest}.
REQ-018 p_ready = (count < 2), decoded from registered count only, with no combinational path from the inputs.
REQ-019 Pipe accept is p_valid && p_ready; an accepted request with p_is_b_type=1 or p_dest=0 is dropped (not enqueued, never written).
REQ-020 Enqueue and dequeue in the same cycle leave count unchanged; count never exceeds 2 or underflows below 0.
REQ-021 Arbiter FSM has two states: ARB_PIPE (reset state) and ARB_FORCE.
REQ-022 In ARB_PIPE, FIFO head is granted if count>0; otherwise m is granted if m_valid.
REQ-023 In ARB_FORCE, m is granted if m_valid; otherwise FIFO head is granted if count>0.
REQ-024 m_ready = m grant, combinational from m_valid, count and state; m holds valid/data/dest stable until m_ready.
REQ-025 Starve counter (4 bits) increments each cycle m_valid=1 and m is not granted; it clears on m grant or m_valid=0.
REQ-026 ARB_PIPE -> ARB_FORCE when the starve counter equals STARVE_LIMIT at a clock edge.
REQ-027 ARB_FORCE -> ARB_PIPE on the cycle m is granted, or when m_valid=0.
REQ-028 At most one grant per cycle; the FIFO dequeues only on a pipe grant.
REQ-029 Latency: a grant in cycle N drives reg_write_enable/write_addr/write_data in cycle N+1.
REQ-030 An m grant with m_dest=0 completes the handshake but produces reg_write_enable=0.
REQ-031 Whenever reg_write_enable=0, write_data=0 and write_addr=0; reg_write_enable=1 never occurs with write_addr=0.
REQ-032 Pipe results are written in acceptance order; no ordering is guaranteed between pipe and m results.
REQ-033 Empty/full boundaries: an empty FIFO with m_valid=0 gives no write next cycle; when count=2, p_ready=0 regardless of an in-flight dequeue.

Reset
REQ-034 While rst=1: count=0, FIFO contents don't-care, state=ARB_PIPE, starve counter=0.
REQ-035 While rst=1: reg_write_enable=0, write_data=0, write_addr=0, p_ready=1, m_ready=0, busy=m_valid.
REQ-036 Reset asserted mid-operation discards buffered entries and any pending grant; no write issues in the cycle after release unless a new grant occurs.

Verification
REQ-037 Pipe request p_dest=5, p_data=0x1234 into an empty FIFO, m idle -> next cycle: enable=1, addr=5, data=0x1234.
REQ-038 Pipe requests p_is_b_type=1 (dest=7), then p_dest=0 (data=0xFFFF) -> both accepted with p_ready=1; enable stays 0 throughout.
REQ-039 With count=2, present a third pipe request -> p_ready=0; a dequeue occurs; p_ready=1 the following cycle; write order matches acceptance order.
REQ-040 STARVE_LIMIT=4, m_valid held (dest=9, data=0xAA) with continuous pipe traffic -> m_ready=1 in the 5th cycle of waiting; next cycle enable=1, addr=9, data=0xAA; FSM returns to ARB_PIPE.
REQ-041 Simultaneous pipe enqueue and dequeue at count=1 -> count stays 1; no entry is lost or duplicated.
REQ-042 rst pulsed with count=2 and ARB_FORCE active -> immediately: outputs 0, p_ready=1, state ARB_PIPE; no write of stale entries after release.
